// File: rtl/image_rotate_reader_if.sv
// image_rotate_reader_if: frame control, frame-buffer read port and pixel stream of the rotation engine; master = engine, slave = environment
interface image_rotate_reader_if #(parameter int ADDR_W = 16, parameter int FRAC = 14);
  logic start;
  logic signed [FRAC+1:0] cos_q;
  logic signed [FRAC+1:0] sin_q;
  logic mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0] mem_rdata;
  logic out_valid;
  logic out_ready;
  logic [7:0] out_pixel;
  logic out_last;
  logic busy;
  logic done;
  modport master (
    input start, cos_q, sin_q, mem_rdata, out_ready,
    output mem_rd_en, mem_addr, out_valid, out_pixel, out_last, busy, done
  );
  modport slave (
    output start, cos_q, sin_q, mem_rdata, out_ready,
    input mem_rd_en, mem_addr, out_valid, out_pixel, out_last, busy, done
  );
endinterface

// File: rtl/image_rotate_reader.sv
// image_rotate_reader: inverse-mapping rotator; clk/rst plus bus (start, cos_q/sin_q in, mem_rd_en/mem_addr/mem_rdata read port, out_valid/out_ready/out_pixel/out_last stream, busy/done)
module image_rotate_reader #(
  parameter int ROWS = 242,
  parameter int COLS = 247,
  parameter int ADDR_W = 16,
  parameter int FRAC = 14
) (
  input logic clk,
  input logic rst,
  image_rotate_reader_if.master bus
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  typedef enum logic [2:0] {IDLE, CALC, READ, WAIT, OUT, DONE} state_t;
  state_t state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic signed [FRAC+1:0] cos_r, sin_r;
  logic signed [31:0] cos_w, sin_w, dx2, dy2, sx_sum, sy_sum, src_x, src_y;
  logic in_bounds, last_px;
  logic [ADDR_W-1:0] addr;
  always_comb begin
    cos_w = 32'(cos_r);
    sin_w = 32'(sin_r);
    dx2 = 2 * int'(col) - (COLS - 1);
    dy2 = 2 * int'(row) - (ROWS - 1);
    sx_sum = cos_w * dx2 + sin_w * dy2 + ((COLS - 1) <<< FRAC);
    sy_sum = cos_w * dy2 - sin_w * dx2 + ((ROWS - 1) <<< FRAC);
    src_x = sx_sum >>> (FRAC + 1);
    src_y = sy_sum >>> (FRAC + 1);
    in_bounds = src_x >= 0 && src_x < COLS && src_y >= 0 && src_y < ROWS;
    addr = ADDR_W'(src_y * COLS + src_x);
    last_px = row == ROW_MAX && col == COL_MAX;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      cos_r <= '0;
      sin_r <= '0;
      bus.mem_rd_en <= 1'b0;
      bus.mem_addr <= '0;
      bus.out_valid <= 1'b0;
      bus.out_pixel <= '0;
      bus.out_last <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          cos_r <= bus.cos_q;
          sin_r <= bus.sin_q;
          row <= '0;
          col <= '0;
          bus.busy <= 1'b1;
          state <= CALC;
        end
        CALC: begin
          bus.out_last <= last_px;
          if (in_bounds) begin
            bus.mem_rd_en <= 1'b1;
            bus.mem_addr <= addr;
            state <= READ;
          end else begin
            bus.out_pixel <= '0;
            bus.out_valid <= 1'b1;
            state <= OUT;
          end
        end
        READ: begin
          bus.mem_rd_en <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          bus.out_pixel <= bus.mem_rdata;
          bus.out_valid <= 1'b1;
          state <= OUT;
        end
        OUT: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          if (bus.out_last) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state <= DONE;
          end else begin
            col <= col == COL_MAX ? '0 : col + CW'(1);
            row <= col == COL_MAX ? row + RW'(1) : row;
            state <= CALC;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_image_rotate_reader.sv
// tb_image_rotate_reader: scoreboard bench for image_rotate_reader on a 6x11 frame
module tb_image_rotate_reader;
  localparam int R = 6;
  localparam int C = 11;
  localparam int AW = 16;
  localparam int F = 14;
  localparam int N = R * C;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  image_rotate_reader_if #(.ADDR_W(AW), .FRAC(F)) bus();
  image_rotate_reader #(.ROWS(R), .COLS(C), .ADDR_W(AW), .FRAC(F)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [7:0] mem [N];
  logic [8:0] exp_q [$];
  int addr_q [$];
  int pass_cnt = 0, chk_cnt = 0;
  int hs_cnt = 0, rd_seen = 0, busy_cnt = 0, done_cnt = 0, last_cnt = 0;
  int hs_mark = 0, rd_mark = 0;
  int first_addr = -1, first_pix = -1, first_reads = -1;
  bit rand_rdy = 1'b0;
  bit held_v = 1'b0;
  logic [8:0] held, e;
  task automatic check(string name, int act, int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  function automatic int outs();
    return int'({bus.mem_rd_en, bus.mem_addr, bus.out_valid, bus.out_pixel, bus.out_last, bus.busy, bus.done});
  endfunction
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= mem[int'(bus.mem_addr) % N];
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2 bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end
  initial forever begin
    @(negedge clk);
    if (rst) held_v = 1'b0;
    else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) done_cnt++;
      if (bus.mem_rd_en) begin
        if (rd_seen == rd_mark) first_addr = int'(bus.mem_addr);
        if (addr_q.size() == 0) check("rd_extra", int'(bus.mem_addr), -1);
        else check("rd_addr", int'(bus.mem_addr), addr_q.pop_front());
        rd_seen++;
      end
      if (held_v && bus.out_valid) check("stall_hold", int'({bus.out_last, bus.out_pixel}), int'(held));
      held_v = bus.out_valid && !bus.out_ready;
      held = {bus.out_last, bus.out_pixel};
      if (bus.out_valid && bus.out_ready) begin
        if (hs_cnt == hs_mark) begin
          first_pix = int'(bus.out_pixel);
          first_reads = rd_seen - rd_mark;
        end
        if (exp_q.size() == 0) check("pix_extra", int'(bus.out_pixel), -1);
        else begin
          e = exp_q.pop_front();
          check("pixel", int'(bus.out_pixel), int'(e[7:0]));
          check("last", int'(bus.out_last), int'(e[8]));
        end
        if (bus.out_last) last_cnt++;
        hs_cnt++;
      end
    end
  end
  task automatic build(int c, int s, output int cyc, output int reads);
    int sx, sy;
    bit inb;
    logic [7:0] p;
    cyc = 0;
    reads = 0;
    for (int y = 0; y < R; y++)
      for (int x = 0; x < C; x++) begin
        sx = int'($floor(real'(c * (2 * x - (C - 1)) + s * (2 * y - (R - 1)) + (C - 1) * 16384) / 32768.0));
        sy = int'($floor(real'(c * (2 * y - (R - 1)) - s * (2 * x - (C - 1)) + (R - 1) * 16384) / 32768.0));
        inb = sx >= 0 && sx < C && sy >= 0 && sy < R;
        p = inb ? mem[sy * C + sx] : 8'd0;
        if (inb) addr_q.push_back(sy * C + sx);
        reads += inb ? 1 : 0;
        cyc += inb ? 4 : 2;
        exp_q.push_back({1'(y == R - 1 && x == C - 1), p});
      end
  endtask
  task automatic launch(int c, int s);
    hs_mark = hs_cnt;
    rd_mark = rd_seen;
    @(posedge clk);
    #2 bus.cos_q = 16'(c);
    bus.sin_q = 16'(s);
    bus.start = 1'b1;
    @(posedge clk);
    #2 bus.start = 1'b0;
    bus.cos_q = 16'($urandom);
    bus.sin_q = 16'($urandom);
  endtask
  task automatic run_frame(int c, int s, bit rnd, bit poke);
    int ecyc, erd, b0, d0, l0;
    build(c, s, ecyc, erd);
    rand_rdy = rnd;
    @(posedge clk);
    b0 = busy_cnt;
    d0 = done_cnt;
    l0 = last_cnt;
    launch(c, s);
    for (int k = 0; k < 5000 && done_cnt == d0; k++) begin
      @(posedge clk);
      #2 bus.start = poke && k == 40;
    end
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    check("done_count", done_cnt - d0, 1);
    check("pixels_left", exp_q.size(), 0);
    check("reads_left", addr_q.size(), 0);
    check("pixel_count", hs_cnt - hs_mark, N);
    check("read_count", rd_seen - rd_mark, erd);
    check("last_count", last_cnt - l0, 1);
    if (!rnd) check("busy_cycles", busy_cnt - b0, ecyc);
    exp_q.delete();
    addr_q.delete();
    rand_rdy = 1'b0;
  endtask
  initial begin
    int ecyc, erd, d0;
    bus.start = 1'b0;
    bus.cos_q = '0;
    bus.sin_q = '0;
    for (int i = 0; i < N; i++) mem[i] = 8'(i * 7 + 1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 check("reset_outputs", outs(), 0);
    rst = 1'b0;
    run_frame(16384, 0, 1'b0, 1'b0);
    check("first_pix_0deg", first_pix, 1);
    check("first_reads_0deg", first_reads, 1);
    run_frame(-16384, 0, 1'b0, 1'b0);
    check("first_addr_180", first_addr, 65);
    check("first_pix_180", first_pix, 200);
    run_frame(0, 16384, 1'b0, 1'b0);
    check("first_pix_90", first_pix, 0);
    check("first_reads_90", first_reads, 0);
    run_frame(8192, 14189, 1'b1, 1'b0);
    run_frame(8192, 14189, 1'b0, 1'b0);
    build(16384, 0, ecyc, erd);
    d0 = done_cnt;
    launch(16384, 0);
    for (int k = 0; k < 2000 && hs_cnt - hs_mark < 20; k++) @(posedge clk);
    check("abort_reached", int'(hs_cnt - hs_mark >= 20), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 check("abort_outputs", outs(), 0);
    rst = 1'b0;
    exp_q.delete();
    addr_q.delete();
    repeat (10) @(posedge clk);
    #2 check("abort_no_done", done_cnt - d0, 0);
    check("abort_idle", outs(), 0);
    run_frame(16384, 0, 1'b0, 1'b0);
    run_frame(-16384, 0, 1'b0, 1'b1);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
